// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, data width and baud divisor helper.
// Used by both the tx and rx sides.
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_tx_state_e;

    // Integer-truncated clocks per bit period.
    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO for uart_tx; show-ahead read data at the head pointer.
// Latency: a push is visible on pop_dat/empty/count the cycle after the push edge.
// Backpressure: push ignored while full (registered count), pop ignored while empty.
module uart_tx_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_dat,
    input  logic                   pop,
    output logic [WIDTH-1:0]       pop_dat,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == FULL_CNT);
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign pop_dat = mem[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; only the pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= push_dat;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with byte FIFO; UART_TX_PARITY_EN adds an even-parity bit (8E1).
// Latency: a byte written into an empty FIFO drives the start bit 2 edges after acceptance.
// Backpressure: wr_ready drops while the FIFO holds FIFO_DEPTH bytes; writes are then refused.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int BAUD        = 115_200,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        wr_valid,
    input  logic [UART_DATA_BITS-1:0]   wr_data,
    output logic                        wr_ready,
    output logic                        tx,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

    localparam int CPB = clks_per_bit(CLK_FREQ_HZ, BAUD);
    localparam int BCW = (CPB > 1) ? $clog2(CPB) : 1;
    localparam logic [BCW-1:0] BAUD_LAST = BCW'(CPB - 1);
    localparam logic [2:0]     LAST_BIT  = 3'(UART_DATA_BITS - 1);

    uart_tx_state_e              state_q, state_d;
    logic [BCW-1:0]              baud_q, baud_d;
    logic [2:0]                  bit_q, bit_d;
    logic [UART_DATA_BITS-1:0]   shift_q, shift_d;
    logic                        tx_q, tx_d;
    logic                        pend_q, pend_d;
`ifdef UART_TX_PARITY_EN
    logic                        parity_q, parity_d;
`endif

    logic                        baud_last;
    logic                        launch;
    logic                        fifo_pop;
    logic                        fifo_full;
    logic                        fifo_empty;
    logic [UART_DATA_BITS-1:0]   fifo_dat;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (UART_DATA_BITS)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (wr_valid),
        .push_dat (wr_data),
        .pop      (fifo_pop),
        .pop_dat  (fifo_dat),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    assign wr_ready  = !fifo_full;
    assign tx        = tx_q;
    assign busy      = (state_q != IDLE) || !fifo_empty;
    assign baud_last = (baud_q == BAUD_LAST);

    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        tx_d     = tx_q;
        launch   = 1'b0;
        fifo_pop = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif

        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                // Launch from the registered non-empty flag, not the live FIFO state.
                if (pend_q) begin
                    launch = 1'b1;
                end
            end
            START: begin
                baud_d = baud_q + 1'b1;
                if (baud_last) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = DATA;
                    tx_d    = shift_q[0];
                end
            end
            DATA: begin
                baud_d = baud_q + 1'b1;
                if (baud_last) begin
                    baud_d = '0;
                    if (bit_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
                        tx_d    = parity_q;
`else
                        state_d = STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        shift_d = shift_q >> 1;
                        tx_d    = shift_q[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                baud_d = baud_q + 1'b1;
                if (baud_last) begin
                    baud_d  = '0;
                    state_d = STOP;
                    tx_d    = 1'b1;
                end
            end
`endif
            STOP: begin
                baud_d = baud_q + 1'b1;
                if (baud_last) begin
                    // Queued byte on the last stop clock chains straight into a new start bit.
                    if (!fifo_empty) begin
                        launch = 1'b1;
                    end else begin
                        baud_d  = '0;
                        state_d = IDLE;
                        tx_d    = 1'b1;
                    end
                end
            end
            default: begin
                baud_d  = '0;
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase

        if (launch) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_dat;
            tx_d     = 1'b0;
            baud_d   = '0;
            bit_d    = '0;
            state_d  = START;
`ifdef UART_TX_PARITY_EN
            parity_d = ^fifo_dat;
`endif
        end

        pend_d = !fifo_empty && !launch;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
            pend_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
            pend_q   <= pend_d;
`ifdef UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

endmodule
